// File: rtl/status_digits_ctrl_if.sv
// Bundle between the game counters and the status-text renderer: frame pulse,
// binary counters in, ASCII digit strings and sequencing flags out.
interface status_digits_ctrl_if #(
  parameter int unsigned BIN_WIDTH    = 20,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned SYMBOL_WIDTH = 7
);
  localparam int unsigned STR_W = DIGITS * SYMBOL_WIDTH;

  logic                 frame_start_i;
  logic [BIN_WIDTH-1:0] score_i;
  logic [BIN_WIDTH-1:0] lines_i;
  logic [BIN_WIDTH-1:0] level_i;
  logic [STR_W-1:0]     score_str_o;
  logic [STR_W-1:0]     lines_str_o;
  logic [STR_W-1:0]     level_str_o;
  logic                 busy_o;
  logic                 update_o;

  modport master (
    output frame_start_i, score_i, lines_i, level_i,
    input  score_str_o, lines_str_o, level_str_o, busy_o, update_o
  );

  modport slave (
    input  frame_start_i, score_i, lines_i, level_i,
    output score_str_o, lines_str_o, level_str_o, busy_o, update_o
  );
endinterface

// File: rtl/status_digits_ctrl.sv
// Frame-synchronous binary-to-ASCII converter for the status panel: one shared
// double-dabble engine converts score, lines and level, then commits all three.
module status_digits_ctrl #(
  parameter int unsigned BIN_WIDTH    = 20,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned SYMBOL_WIDTH = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  status_digits_ctrl_if.slave bus
);

  localparam int unsigned STR_W  = DIGITS * SYMBOL_WIDTH;
  localparam int unsigned BCD_W  = (DIGITS + 1) * 4;
  localparam int unsigned ITER_W = $clog2(BIN_WIDTH + 1);

  localparam logic [ITER_W-1:0]       LAST_ITER = ITER_W'(BIN_WIDTH - 1);
  localparam logic [SYMBOL_WIDTH-1:0] SYM_SPACE = SYMBOL_WIDTH'(7'h20);
  localparam logic [SYMBOL_WIDTH-1:0] SYM_ZERO  = SYMBOL_WIDTH'(7'h30);
  localparam logic [SYMBOL_WIDTH-1:0] SYM_NINE  = SYMBOL_WIDTH'(7'h39);
  localparam logic [STR_W-1:0]        RESET_STR = {{(DIGITS-1){SYM_SPACE}}, SYM_ZERO};

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [BIN_WIDTH-1:0] snap_q [3];
  logic [BIN_WIDTH-1:0] snap_d [3];
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic [STR_W-1:0]     shadow_q [3];
  logic [STR_W-1:0]     shadow_d [3];
  logic [STR_W-1:0]     score_str_q, score_str_d;
  logic [STR_W-1:0]     lines_str_q, lines_str_d;
  logic [STR_W-1:0]     level_str_q, level_str_d;
  logic                 busy_q, busy_d;
  logic                 update_q, update_d;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
  function automatic logic [BCD_W+BIN_WIDTH-1:0] dabble_step(
    input logic [BCD_W-1:0]     bcd,
    input logic [BIN_WIDTH-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  // The extra top nibble is non-zero exactly when the value exceeds DIGITS
  // decimal digits, so it doubles as the saturation flag.
  function automatic logic [STR_W-1:0] format_str(input logic [BCD_W-1:0] bcd);
    logic [STR_W-1:0] s;
    logic [3:0]       nib;
    logic             seen;
    s    = '0;
    seen = 1'b0;
    if (bcd[BCD_W-1 -: 4] != 4'd0) begin
      s = {DIGITS{SYM_NINE}};
    end else begin
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
        nib  = bcd[i*4 +: 4];
        seen = seen | (nib != 4'd0);
        if (seen || i == 0) s[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYM_ZERO + SYMBOL_WIDTH'(nib);
        else                s[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYM_SPACE;
      end
    end
    return s;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      score_str_q <= RESET_STR;
      lines_str_q <= RESET_STR;
      level_str_q <= RESET_STR;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= RESET_STR;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      score_str_q <= score_str_d;
      lines_str_q <= lines_str_d;
      level_str_q <= level_str_d;
      busy_q      <= busy_d;
      update_q    <= update_d;
      for (int i = 0; i < 3; i++) begin
        snap_q[i]   <= snap_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    snap_d      = snap_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    shadow_d    = shadow_q;
    score_str_d = score_str_q;
    lines_str_d = lines_str_q;
    level_str_d = level_str_q;
    busy_d      = busy_q;
    update_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start_i) begin
          snap_d[0] = bus.score_i;
          snap_d[1] = bus.lines_i;
          snap_d[2] = bus.level_i;
          sel_d     = 2'd0;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bin_d   = snap_q[sel_q];
        bcd_d   = '0;
        iter_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
        iter_d         = iter_q + ITER_W'(1);
        if (iter_q == LAST_ITER) state_d = STORE;
      end
      STORE: begin
        shadow_d[sel_q] = format_str(bcd_q);
        if (sel_q == 2'd2) begin
          state_d = COMMIT;
        end else begin
          sel_d   = sel_q + 2'd1;
          state_d = LOAD;
        end
      end
      COMMIT: begin
        score_str_d = shadow_q[0];
        lines_str_d = shadow_q[1];
        level_str_d = shadow_q[2];
        update_d    = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.score_str_o = score_str_q;
  assign bus.lines_str_o = lines_str_q;
  assign bus.level_str_o = level_str_q;
  assign bus.busy_o      = busy_q;
  assign bus.update_o    = update_q;

endmodule

// File: doc/status_digits_ctrl.md
# status_digits_ctrl

Frame-synchronous sequencer that converts the three binary game counters (score, lines, level) into the ASCII digit strings consumed by the status-text renderer. A single iterative binary-to-BCD engine (double-dabble) is time-shared among the three counters. Conversion starts on a per-frame pulse. All three strings are committed to the outputs in the same cycle, so the renderer never shows a half-updated status panel. Leading-zero blanking and saturation are applied here, so the renderer only maps symbols to font rows.

## Interface

Parameters:
- BIN_WIDTH, 20, width of each binary counter input.
- DIGITS, 6, number of decimal digits per output string.
- SYMBOL_WIDTH, 7, bits per ASCII symbol.

Ports:
- clk_i  input  1  system/pixel clock; single clock domain.
- rst_i  input  1  asynchronous, active-high reset.
- frame_start_i  input  1  one-cycle pulse at the start of vertical blanking.
- score_i  input  BIN_WIDTH  binary score.
- lines_i  input  BIN_WIDTH  binary cleared-lines count.
- level_i  input  BIN_WIDTH  binary level.
- score_str_o  output  DIGITS*SYMBOL_WIDTH  ASCII score string; symbol i is bits [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]; i=0 is the least-significant digit.
- lines_str_o  output  DIGITS*SYMBOL_WIDTH  same layout, lines count.
- level_str_o  output  DIGITS*SYMBOL_WIDTH  same layout, level.
- busy_o  output  1  high while a conversion sequence is in progress.
- update_o  output  1  one-cycle pulse in the cycle the new strings first appear.

## Operation

State machine states: IDLE, LOAD, SHIFT, STORE, COMMIT. A 2-bit selector sel chooses the counter: 0 = score, 1 = lines, 2 = level.

- IDLE
  - If frame_start_i is high, snapshot score_i, lines_i and level_i into internal registers, set sel=0, and go to LOAD.
  - frame_start_i is ignored in every other state; there is no queueing.
- LOAD
  - Load the shift register with snapshot[sel].
  - Clear the BCD accumulator, which is DIGITS+1 nibbles wide.
  - Clear the iteration counter, then go to SHIFT.
- SHIFT
  - One double-dabble step per cycle: add 3 to every BCD nibble that is ≥5, then shift {BCD, bin} left by 1.
  - After exactly BIN_WIDTH steps, go to STORE.
- STORE
  - Format the result into shadow[sel].
  - If sel==2, go to COMMIT; otherwise increment sel and go to LOAD.
- COMMIT
  - Copy all three shadows to the string outputs simultaneously.
  - Assert update_o for one cycle, then go to IDLE.

Formatting, applied in STORE:
- Saturation: if snapshot[sel] > 10^DIGITS − 1, every symbol becomes 7'h39 ('9').
- Digit mapping: otherwise, symbol i = BCD nibble i + 7'h30.
- Leading-zero blanking: symbols above the most-significant non-zero digit become 7'h20 (space).
- Symbol 0 is never blanked, so a value of 0 yields five spaces followed by '0'.

Inputs changing after the snapshot have no effect on the sequence in progress.

## Timing

- Reset values:
  - State IDLE, sel 0, busy_o 0, update_o 0.
  - Every string output is symbols 5..1 = 7'h20 and symbol 0 = 7'h30 (displays "     0").
  - Shadows take the same reset value as the outputs.
- Latency: let E0 be the clock edge that samples frame_start_i high in IDLE.
  - Each counter takes BIN_WIDTH+2 edges: LOAD 1, SHIFT BIN_WIDTH, STORE 1.
  - COMMIT executes at E0 + 3*(BIN_WIDTH+2) + 1, which is E67 at the defaults.
  - New strings and update_o=1 are visible after that edge; update_o returns to 0 after the next edge.
- busy_o:
  - Rises after E0.
  - Falls after the COMMIT edge, in the same cycle update_o is high.
  - A frame_start_i arriving on the cycle busy_o falls is accepted, because the state is already IDLE at that edge.
- Outputs are stable between COMMIT edges; they never change outside COMMIT except on reset.
- Reset mid-sequence: rst_i asserted in any state immediately returns every register to its reset value. Partially built shadows are discarded and update_o is not pulsed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset check: assert rst_i mid-SHIFT → all strings read "     0", busy_o=0, update_o=0, and no update_o pulse follows.
- Small values: score=5, lines=0, level=12, pulse frame_start_i → update_o exactly 67 cycles after the sampling edge; strings "     5", "     0", "    12".
- Full width: score=123456, lines=100000, level=999999 → "123456", "100000", "999999"; no blanking.
- Saturation: score=1_000_000, lines=2^20−1 → both strings "999999"; level unaffected.
- Snapshot and ignore rules:
  - Change score_i from 7 to 8 one cycle after the start pulse → the result shows "     7".
  - A second frame_start_i pulse while busy_o=1 → no extra update_o pulse.
  - A pulse on the cycle busy_o falls → a second sequence starts.
- Output stability: toggle the inputs for 1000 cycles without frame_start_i → strings and update_o unchanged.
